// File: rtl/slurm16_mem_pkg.sv
// Shared encodings and default widths for the slurm16 memory arbiter.
package slurm16_mem_pkg;

  localparam int BITS_DEF         = 16;
  localparam int ADDRESS_BITS_DEF = 16;

  // Requester slots in eligibility / grant vectors.
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  // Which requester owns the access currently in flight in the RAM.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_CPU  = 2'd1,
    GRANT_DMA  = 2'd2
  } grant_t;

  // One-hot grant vector to owner encoding.
  function automatic grant_t onehot_to_grant(input logic [1:0] gnt);
    if (gnt[REQ_CPU])      return GRANT_CPU;
    else if (gnt[REQ_DMA]) return GRANT_DMA;
    else                   return GRANT_NONE;
  endfunction

endpackage

// File: rtl/slurm16_memory_arbiter_if.sv
// Request/response bundle of one slurm16 memory requester.
interface slurm16_memory_arbiter_if #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
);
  logic [ADDRESS_BITS-1:0] address;
  logic [BITS-1:0]         wdata;
  logic                    valid;
  logic                    wr;
  logic                    ready;
  logic [BITS-1:0]         rdata;

  modport master (output address, wdata, valid, wr, input  ready, rdata);
  modport slave  (input  address, wdata, valid, wr, output ready, rdata);
endinterface

// File: rtl/slurm16_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module slurm16_rr_arbiter2
  import slurm16_mem_pkg::*;
(
  input  logic [1:0] elig,
  input  grant_t     last_grant,
  output logic [1:0] gnt
);

  // Combinational one-hot grant from eligibility and last winner.
  always_comb begin
    gnt = 2'b00;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GRANT_CPU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/slurm16_memory_arbiter.sv
// CPU/DMA sharing one single-port synchronous RAM: one access per cycle,
// round-robin on contention, one-cycle ready pulse back to the winner.
module slurm16_memory_arbiter
  import slurm16_mem_pkg::*;
#(
  parameter int BITS         = BITS_DEF,
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  slurm16_memory_arbiter_if.slave cpu,
  slurm16_memory_arbiter_if.slave dma,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic [BITS-1:0]         ram_wdata,
  output logic                    ram_en,
  output logic                    ram_wr,
  input  logic [BITS-1:0]         ram_rdata
);

  grant_t     issued;
  grant_t     last_grant;
  logic       cpu_ready_q;
  logic       dma_ready_q;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic [1:0] gnt_q;

  // A requester whose access was issued last cycle is in its ready cycle
  // with valid still high; it must not be served twice.
  assign elig[REQ_CPU] = cpu.valid && (issued != GRANT_CPU);
  assign elig[REQ_DMA] = dma.valid && (issued != GRANT_DMA);

  slurm16_rr_arbiter2 u_rr (
    .elig       (elig),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // No RAM access leaves the block while reset is asserted.
  assign gnt_q = gnt & {2{RSTb}};

  // Steer the winner onto the RAM port; all zero when idle.
  always_comb begin
    ram_en      = |gnt_q;
    ram_wr      = 1'b0;
    ram_address = '0;
    ram_wdata   = '0;
    if (gnt_q[REQ_CPU]) begin
      ram_wr      = cpu.wr;
      ram_address = cpu.address;
      ram_wdata   = cpu.wdata;
    end else if (gnt_q[REQ_DMA]) begin
      ram_wr      = dma.wr;
      ram_address = dma.address;
      ram_wdata   = dma.wdata;
    end
  end

  // Track the in-flight owner, the last winner and the ready pulses.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      issued      <= GRANT_NONE;
      last_grant  <= GRANT_DMA;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
    end else begin
      issued      <= onehot_to_grant(gnt_q);
      cpu_ready_q <= gnt_q[REQ_CPU];
      dma_ready_q <= gnt_q[REQ_DMA];
      if (|gnt_q) last_grant <= onehot_to_grant(gnt_q);
    end
  end

  assign cpu.ready = cpu_ready_q;
  assign dma.ready = dma_ready_q;

  // Read data is shared; the ready pulse alone marks it as meaningful.
  assign cpu.rdata = ram_rdata;
  assign dma.rdata = ram_rdata;

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Directed scenarios plus a randomized run scored against a cycle-level
// model of the arbitration rules and a reference copy of RAM contents.
module tb_slurm16_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic [15:0] ram_address, ram_wdata, ram_rdata;
  logic        ram_en, ram_wr;

  always #5 CLK = ~CLK;

  slurm16_memory_arbiter_if #(.BITS(16), .ADDRESS_BITS(16)) cpu_if ();
  slurm16_memory_arbiter_if #(.BITS(16), .ADDRESS_BITS(16)) dma_if ();

  slurm16_memory_arbiter #(.BITS(16), .ADDRESS_BITS(16)) dut (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .cpu         (cpu_if),
    .dma         (dma_if),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_en      (ram_en),
    .ram_wr      (ram_wr),
    .ram_rdata   (ram_rdata)
  );

  // Synchronous single-port RAM with a backdoor load port for preloading.
  logic [15:0] mem [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr, bd_data;
  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en) begin
      ram_rdata <= mem[ram_address];
      if (ram_wr) mem[ram_address] <= ram_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset;
    RSTb = 1'b0;
    cpu_if.valid = 1'b1; cpu_if.wr = 1'b0; cpu_if.address = 16'h1111; cpu_if.wdata = 16'h0;
    dma_if.valid = 1'b1; dma_if.wr = 1'b0; dma_if.address = 16'h2222; dma_if.wdata = 16'h0;
    repeat (3) tick();
    checks++;
    if ({ram_en, ram_wr, cpu_if.ready, dma_if.ready} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {ram_en, ram_wr, cpu_if.ready, dma_if.ready});
    end
    checks++;
    if ({ram_address, ram_wdata} !== 32'h0) begin
      failures++; $display("FAIL reset_bus got=%h exp=0", {ram_address, ram_wdata});
    end
    RSTb = 1'b1; #1;
    checks++;
    if (ram_en !== 1'b1 || ram_address !== 16'h1111) begin
      failures++; $display("FAIL reset_first_cpu got en=%b addr=%h exp en=1 addr=1111", ram_en, ram_address);
    end
    tick();
    checks++;
    if ({cpu_if.ready, dma_if.ready} !== 2'b10 || ram_en !== 1'b1 || ram_address !== 16'h2222) begin
      failures++; $display("FAIL reset_then_dma got rdy=%b en=%b addr=%h exp rdy=10 en=1 addr=2222",
                           {cpu_if.ready, dma_if.ready}, ram_en, ram_address);
    end
    tick();
    cpu_if.valid = 1'b0; #1;
    checks++;
    if ({cpu_if.ready, dma_if.ready} !== 2'b01 || ram_en !== 1'b0) begin
      failures++; $display("FAIL reset_dma_ready got rdy=%b en=%b exp rdy=01 en=0", {cpu_if.ready, dma_if.ready}, ram_en);
    end
    tick();
    dma_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read;
    bd_write(16'h1234, 16'hBEEF);
    cpu_if.valid = 1'b1; cpu_if.wr = 1'b0; cpu_if.address = 16'h1234; #1;
    checks++;
    if (ram_en !== 1'b1 || ram_wr !== 1'b0 || ram_address !== 16'h1234) begin
      failures++; $display("FAIL cpu_read_issue got en=%b wr=%b addr=%h exp 1 0 1234", ram_en, ram_wr, ram_address);
    end
    tick();
    checks++;
    if (cpu_if.ready !== 1'b1 || cpu_if.rdata !== 16'hBEEF || dma_if.ready !== 1'b0) begin
      failures++; $display("FAIL cpu_read_done got rdy=%b data=%h exp rdy=1 data=beef", cpu_if.ready, cpu_if.rdata);
    end
    checks++;
    if (ram_en !== 1'b0) begin
      failures++; $display("FAIL cpu_read_no_dup got en=%b exp 0", ram_en);
    end
    tick();
    cpu_if.valid = 1'b0; #1;
    checks++;
    if (cpu_if.ready !== 1'b0) begin
      failures++; $display("FAIL cpu_read_single_pulse got rdy=%b exp 0", cpu_if.ready);
    end
    tick();
  endtask

  task automatic test_dma_write;
    dma_if.valid = 1'b1; dma_if.wr = 1'b1; dma_if.address = 16'h0040; dma_if.wdata = 16'h5A5A; #1;
    checks++;
    if ({ram_en, ram_wr} !== 2'b11 || ram_address !== 16'h0040 || ram_wdata !== 16'h5A5A) begin
      failures++; $display("FAIL dma_write_issue got en=%b wr=%b addr=%h wd=%h exp 1 1 0040 5a5a",
                           ram_en, ram_wr, ram_address, ram_wdata);
    end
    tick();
    checks++;
    if (dma_if.ready !== 1'b1 || ram_en !== 1'b0 || mem[16'h0040] !== 16'h5A5A) begin
      failures++; $display("FAIL dma_write_done got rdy=%b en=%b mem=%h exp 1 0 5a5a", dma_if.ready, ram_en, mem[16'h0040]);
    end
    tick();
    dma_if.valid = 1'b0; dma_if.wr = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    logic [15:0] ca, da, exp_a;
    bit cpn, dpn;
    ca = 16'h1000; da = 16'h2000; cpn = 0; dpn = 0;
    cpu_if.valid = 1'b1; cpu_if.wr = 1'b0; cpu_if.address = ca;
    dma_if.valid = 1'b1; dma_if.wr = 1'b0; dma_if.address = da;
    for (int k = 0; k < 10; k++) begin
      if (cpn) begin ca = ca + 16'h1; cpu_if.address = ca; cpn = 0; end
      if (dpn) begin da = da + 16'h1; dma_if.address = da; dpn = 0; end
      if (cpu_if.ready) cpn = 1;
      if (dma_if.ready) dpn = 1;
      #1;
      exp_a = (k % 2 == 0) ? ca : da;
      checks++;
      if (ram_en !== 1'b1 || ram_address !== exp_a) begin
        failures++; $display("FAIL contention_k%0d got en=%b addr=%h exp en=1 addr=%h", k, ram_en, ram_address, exp_a);
      end
      tick();
    end
    cpu_if.valid = 1'b0; dma_if.valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_op;
    bd_write(16'h0077, 16'hC0DE);
    cpu_if.valid = 1'b1; cpu_if.wr = 1'b0; cpu_if.address = 16'h0077; #1;
    checks++;
    if (ram_en !== 1'b1 || ram_address !== 16'h0077) begin
      failures++; $display("FAIL midrst_issue got en=%b addr=%h exp 1 0077", ram_en, ram_address);
    end
    tick();
    RSTb = 1'b0; #1;
    checks++;
    if (cpu_if.ready !== 1'b0 || ram_en !== 1'b0) begin
      failures++; $display("FAIL midrst_dropped got rdy=%b en=%b exp 0 0", cpu_if.ready, ram_en);
    end
    tick();
    RSTb = 1'b1; #1;
    checks++;
    if (ram_en !== 1'b1 || ram_address !== 16'h0077) begin
      failures++; $display("FAIL midrst_reissue got en=%b addr=%h exp 1 0077", ram_en, ram_address);
    end
    tick();
    checks++;
    if (cpu_if.ready !== 1'b1 || cpu_if.rdata !== 16'hC0DE) begin
      failures++; $display("FAIL midrst_complete got rdy=%b data=%h exp 1 c0de", cpu_if.ready, cpu_if.rdata);
    end
    tick();
    cpu_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_random;
    logic [15:0] ref_mem [0:15];
    logic        r_valid [2];
    logic        r_wr    [2];
    logic [15:0] r_addr  [2];
    logic [15:0] r_wdata [2];
    logic [15:0] exp_rd  [2];
    bit          r_fresh [2];
    int          r_age   [2];
    int          m_issued, m_last, win;
    bit          elig [2];
    logic        got_rdy;
    logic [15:0] got_rd, d;
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      ref_mem[i] = d;
      bd_write(16'(i), d);
    end
    for (int r = 0; r < 2; r++) begin
      r_valid[r] = 0; r_wr[r] = 0; r_addr[r] = 0; r_wdata[r] = 0;
      exp_rd[r] = 0; r_fresh[r] = 0; r_age[r] = 0;
    end
    RSTb = 1'b0; tick(); RSTb = 1'b1;
    m_issued = 0; m_last = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        got_rdy = (r == 0) ? cpu_if.ready : dma_if.ready;
        got_rd  = (r == 0) ? cpu_if.rdata : dma_if.rdata;
        checks++;
        if (got_rdy !== (m_issued == r + 1)) begin
          failures++; $display("FAIL rnd_ready%0d cyc=%0d got=%b exp=%b", r, cyc, got_rdy, (m_issued == r + 1));
        end
        if (m_issued == r + 1 && !r_wr[r]) begin
          checks++;
          if (got_rd !== exp_rd[r]) begin
            failures++; $display("FAIL rnd_rdata%0d cyc=%0d got=%h exp=%h", r, cyc, got_rd, exp_rd[r]);
          end
        end
        if (m_issued == r + 1) r_fresh[r] = 1;
        else if (r_fresh[r] || !r_valid[r]) begin
          r_fresh[r] = 0; r_age[r] = 0;
          r_valid[r] = ($urandom_range(0, 3) != 0);
          r_addr[r]  = 16'($urandom_range(0, 15));
          r_wr[r]    = 1'($urandom_range(0, 1));
          r_wdata[r] = 16'($urandom);
        end
      end
      cpu_if.valid = r_valid[0]; cpu_if.wr = r_wr[0]; cpu_if.address = r_addr[0]; cpu_if.wdata = r_wdata[0];
      dma_if.valid = r_valid[1]; dma_if.wr = r_wr[1]; dma_if.address = r_addr[1]; dma_if.wdata = r_wdata[1];
      #1;
      for (int r = 0; r < 2; r++) elig[r] = r_valid[r] && (m_issued != r + 1);
      if (elig[0] && elig[1]) win = (m_last == 1) ? 0 : 1;
      else if (elig[0])       win = 0;
      else if (elig[1])       win = 1;
      else                    win = -1;
      checks++;
      if (ram_en !== (win >= 0)) begin
        failures++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", cyc, ram_en, (win >= 0));
      end
      if (win >= 0) begin
        checks++;
        if (ram_address !== r_addr[win] || ram_wr !== r_wr[win] || (r_wr[win] && ram_wdata !== r_wdata[win])) begin
          failures++; $display("FAIL rnd_bus cyc=%0d got a=%h w=%b d=%h exp a=%h w=%b d=%h", cyc,
                               ram_address, ram_wr, ram_wdata, r_addr[win], r_wr[win], r_wdata[win]);
        end
        if (r_wr[win]) ref_mem[r_addr[win][3:0]] = r_wdata[win];
        else           exp_rd[win] = ref_mem[r_addr[win][3:0]];
      end else begin
        checks++;
        if (ram_wr !== 1'b0) begin
          failures++; $display("FAIL rnd_idle_wr cyc=%0d got=%b exp=0", cyc, ram_wr);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r_valid[r] && m_issued != r + 1 && win != r) begin
          r_age[r]++;
          checks++;
          if (r_age[r] > 1) begin
            failures++; $display("FAIL rnd_wait%0d cyc=%0d got=%0d exp<=1", r, cyc, r_age[r]);
          end
        end
      end
      m_issued = win + 1;
      if (win >= 0) m_last = win;
      tick();
    end
    cpu_if.valid = 1'b0; dma_if.valid = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_contention();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slurm16_memory_arbiter.md
# slurm16_memory_arbiter

Memory-side responder for the slurm16 memory request protocol. Two requesters share one single-port synchronous RAM port:
- the CPU (`memory_address`/`memory_valid`/`memory_wr`/`memory_out` in, `memory_ready`/`memory_in` out);
- a DMA/peripheral master using the same handshake.

The block arbitrates round-robin, issues one RAM access per cycle, and returns a one-cycle `ready` pulse with read data to the requester that won.

## Interface
Parameters:
- `BITS`, 16, data width
- `ADDRESS_BITS`, 16, address width

Ports:
- `CLK`  in  1  system clock; all state on rising edge
- `RSTb`  in  1  reset, asynchronous, active-low
- `cpu_address`  in  ADDRESS_BITS  CPU request address
- `cpu_wdata`  in  BITS  CPU write data
- `cpu_valid`  in  1  CPU request pending; held until `cpu_ready`
- `cpu_wr`  in  1  CPU request is a write
- `cpu_ready`  out  1  one-cycle completion pulse to CPU
- `cpu_rdata`  out  BITS  read data, valid when `cpu_ready`=1
- `dma_address`, `dma_wdata`, `dma_valid`, `dma_wr`, `dma_ready`, `dma_rdata`: same as the `cpu_*` ports, for the DMA requester
- `ram_address`  out  ADDRESS_BITS  RAM address
- `ram_wdata`  out  BITS  RAM write data
- `ram_en`  out  1  RAM access this cycle
- `ram_wr`  out  1  RAM write strobe (qualified by `ram_en`)
- `ram_rdata`  in  BITS  RAM read data, one cycle after `ram_en`

## Operation
- Eligibility in cycle t: requester X is eligible iff `X_valid`=1 and X was not issued in cycle t-1. X's `valid` is still high in the ready cycle, so this rule prevents a duplicate access.
- Arbitration:
  - one eligible requester: it is issued;
  - both eligible: the requester not recorded in `last_grant` is issued;
  - none eligible: `ram_en`=0.
- Issue in cycle t: `ram_en`=1, with `ram_address`/`ram_wdata`/`ram_wr` muxed combinationally from the winner. Register `issued` <= {NONE, CPU, DMA}. `last_grant` <= winner, updated only on an actual issue.
- Completion in cycle t+1: `X_ready`=1 for exactly one cycle if `issued`==X.
  - `cpu_rdata` and `dma_rdata` both carry `ram_rdata` unconditionally; only the ready pulse qualifies them.
  - Writes complete the same way; rdata is don't-care.
- States of `issued`: NONE, CPU, DMA. Every state can move to any state each cycle, as arbitration dictates. `last_grant` encodes CPU or DMA.
- Throughput: both requesters busy gives alternating CPU/DMA, one access per cycle. A single requester gets at most one access per 2 cycles.
- Requesters must not change address/wr/wdata while valid=1 and ready has not yet been seen. After ready, a new request may be presented in the next cycle.
- A requester dropping `valid` before its ready is illegal. The arbiter still completes an access that was already issued.

## Timing
- Reset, while `RSTb`=0:
  - `issued`=NONE, `last_grant`=DMA, so the CPU wins the first tie;
  - `cpu_ready`=`dma_ready`=0;
  - `ram_en`=0 and `ram_wr`=0, gated by `RSTb`;
  - `ram_address`/`ram_wdata`=0.
- Reset mid-operation: an access issued but not yet completed is dropped and no ready pulse is produced. A requester still holding valid is re-issued in the first cycle after `RSTb` rises.
- Latency: from valid high (requester eligible, uncontested) to ready is 1 cycle. Worst case under contention is 2 cycles, because the loser is guaranteed eligible and preferred next cycle.
- Simultaneous events:
  - X's ready cycle coincides with the other requester's new valid: the other is issued in that same cycle;
  - a requester that just received ready and reasserts valid on the next cycle is eligible immediately.
- `ram_*` outputs are combinational from `valid` inputs and registered state. No combinational path from `ram_rdata` to any `ram_*` output.

## Structure
- Shared package `slurm16_mem_pkg`: `issued` encodings GRANT_NONE=2'd0, GRANT_CPU=2'd1, GRANT_DMA=2'd2; default widths BITS/ADDRESS_BITS=16.
- Sub-module `slurm16_rr_arbiter2`:
  - inputs: eligibility vector, `last_grant`;
  - output: one-hot grant;
  - purely combinational; `last_grant` register stays in the top.
- Top: eligibility logic, `issued`/`last_grant` registers, request mux, ready generation, rdata fan-out.

## Test plan
- Reset: hold `RSTb`=0 with both valids high → `ram_en`=0, both readys 0. Release → cycle 1: CPU issued (`ram_address`=`cpu_address`). Cycle 2: `cpu_ready`=1, DMA issued.
- CPU read alone: `cpu_valid`=1, addr 0x1234, RAM returns 0xBEEF → `ram_en` in cycle 0, `cpu_ready`=1 and `cpu_rdata`=0xBEEF in cycle 1, `ram_en`=0 in cycle 1 (no duplicate).
- DMA write alone: addr 0x0040, wdata 0x5A5A → `ram_en`=`ram_wr`=1 with those values for one cycle, `dma_ready` next cycle, RAM contents updated.
- Contention: both held valid for 10 cycles (each reasserting after ready) → grants alternate CPU, DMA, CPU…; `ram_en`=1 every cycle; neither waits more than 2 cycles.
- Reset mid-operation: assert `RSTb`=0 in the cycle after a CPU issue → no `cpu_ready`. After release, the CPU access is re-issued and completes normally.
